// File: rtl/series_requester_pkg.sv
// Shared definitions for the series requester: FSM encoding and watchdog defaults.
package series_requester_pkg;

  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  // Plain vector constants so the state register stays a legacy-friendly logic [1:0].
  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_LAUNCH    = LAUNCH;
  localparam logic [1:0] ST_WAIT_ACK  = WAIT_ACK;
  localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

  // Watchdog value at which a stalled job is abandoned.
  function automatic logic [7:0] wd_limit(input int timeout);
    return 8'(timeout - 1);
  endfunction

endpackage

// File: rtl/series_requester_if.sv
// Host, engine and consumer handshake signals of the series requester.
interface series_requester_if #(
  parameter int XW = 8,
  parameter int RW = 16
);
  logic          in_valid;
  logic [XW-1:0] in_data;
  logic          in_ready;
  logic          eng_start;
  logic [XW-1:0] eng_x;
  logic          eng_busy;
  logic          eng_ready;
  logic [RW-1:0] eng_result;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_ready;

  // Requester side.
  modport slave (
    input  in_valid, in_data, eng_busy, eng_ready, eng_result, out_ready,
    output in_ready, eng_start, eng_x, out_valid, out_data
  );

  // Host / engine / consumer side.
  modport master (
    output in_valid, in_data, eng_busy, eng_ready, eng_result, out_ready,
    input  in_ready, eng_start, eng_x, out_valid, out_data
  );
endinterface

// File: rtl/series_requester_result_fifo2.sv
// Two-entry result FIFO; push while full is accepted only together with a pop.
module result_fifo2 #(
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [RW-1:0] push_data,
  input  logic          pop,
  output logic [RW-1:0] head,
  output logic          full,
  output logic          empty
);

  logic [RW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two storage words are reset so the head reads zero out of reset;
      // at this depth that costs nothing and keeps out_data deterministic.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so a push and pop on the same edge see a consistent occupancy.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/series_requester.sv
// Launches one operand at a time into a series engine, guards it with a watchdog,
// and queues results in a two-entry FIFO.
module series_requester
  import series_requester_pkg::*;
#(
  parameter int XW      = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  series_requester_if.slave   bus,
  output logic                err,
  output logic [7:0]          jobs
);

  localparam logic [7:0] WD_LIMIT = wd_limit(TIMEOUT);

  logic [1:0]    state;
  logic [XW-1:0] eng_x_q;
  logic [7:0]    wd;
  logic [7:0]    wd_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          done;
  logic          expired;
  logic          push;
  logic          pop;

  // The in_ready gate leaves a free FIFO slot for every job in flight.
  assign bus.in_ready  = (state == ST_IDLE) && !fifo_full;
  assign bus.eng_start = (state == ST_LAUNCH);
  assign bus.eng_x     = eng_x_q;
  assign bus.out_valid = !fifo_empty;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = done;

  // Job completion and watchdog expiry for the current wait state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    wd_next = wd + 8'd1;
    done    = 1'b0;
    expired = 1'b0;
    if (state == ST_WAIT_DONE) begin
      done = bus.eng_ready && !bus.eng_busy;
    end
    if ((state == ST_WAIT_ACK && !bus.eng_busy) || (state == ST_WAIT_DONE && !done)) begin
      expired = (wd_next == WD_LIMIT);
    end
  end

  // Sequencer: accept, launch, wait for busy, wait for result or watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      eng_x_q <= '0;
      wd      <= 8'd0;
      err     <= 1'b0;
      jobs    <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            eng_x_q <= bus.in_data;
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd    <= 8'd0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          wd <= wd_next;
          if (bus.eng_busy) begin
            state <= ST_WAIT_DONE;
          end else if (expired) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          wd <= wd_next;
          if (done) begin
            jobs  <= jobs + 8'd1;
            state <= ST_IDLE;
          end else if (expired) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  result_fifo2 #(.RW(RW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.eng_result),
    .pop       (pop),
    .head      (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/series_requester.md
SERIES_REQUESTER -- requirements
Module: series_requester

Interface
REQ-001 Parameter XW, 8: operand width.
REQ-002 Parameter RW, 16: result width.
REQ-003 Parameter TIMEOUT, 64: watchdog limit in cycles; legal range 2..255.
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand x offered by the host.
REQ-007 in_data  in  XW  operand x.
REQ-008 in_ready  out  1  requester accepts an operand this cycle.
REQ-009 eng_start  out  1  one-cycle launch pulse to the series engine.
REQ-010 eng_x  out  XW  operand presented to the engine.
REQ-011 eng_busy  in  1  engine is computing.
REQ-012 eng_ready  in  1  engine is idle and its result is valid.
REQ-013 eng_result  in  RW  engine sum output.
REQ-014 out_valid  out  1  result FIFO is non-empty.
REQ-015 out_data  out  RW  FIFO head result.
REQ-016 out_ready  in  1  consumer pops the head.
REQ-017 err  out  1  sticky timeout flag.
REQ-018 jobs  out  8  count of completed jobs; wraps 255->0.

Function
REQ-019 FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
REQ-020 in_ready SHALL be 1 only when state is IDLE and FIFO count is not 2.
REQ-021 On in_valid&&in_ready at edge N: latch in_data into eng_x and go to LAUNCH; eng_start=1 during cycle N+1 only.
REQ-022 eng_x SHALL remain stable from LAUNCH until the state returns to IDLE.
REQ-023 LAUNCH SHALL always go to WAIT_ACK on the next edge.
REQ-024 WAIT_ACK: eng_busy=1 -> WAIT_DONE; otherwise hold.
REQ-025 WAIT_DONE: eng_ready=1 && eng_busy=0 -> push eng_result into the FIFO on that edge, increment jobs, go to IDLE.
REQ-026 Watchdog: cleared in LAUNCH, increments each cycle in WAIT_ACK/WAIT_DONE; on reaching TIMEOUT-1 without the exit condition: set err, no push, jobs unchanged, go to IDLE.
REQ-027 Result FIFO: depth 2; out_valid = (count!=0); pop on out_valid&&out_ready; simultaneous push and pop keeps count and preserves order.
REQ-028 A push SHALL never be lost: the REQ-020 gate guarantees a free slot at completion.
REQ-029 out_data SHALL be the head entry, valid the cycle after the push edge when the FIFO was empty.
REQ-030 err SHALL be cleared only by reset.

Reset
REQ-031 Asserting reset at any time (including mid-job) SHALL force: state IDLE, eng_start 0, eng_x 0, watchdog 0, FIFO empty (out_valid 0, out_data 0), jobs 0, err 0.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 The state encoding (2-bit enum) and the default TIMEOUT constant SHALL live in a shared series package.
REQ-034 The 2-entry FIFO SHALL be a sub-module named result_fifo2 (parameter RW; push/pop/full/empty ports).

Verification
REQ-035 Single job: x=8'h05; engine raises busy 2 cycles after start and ready 20 cycles later with result 16'h1234 -> exactly one eng_start pulse; eng_x=8'h05 throughout; out_valid with 16'h1234; jobs=1.
REQ-036 Backpressure: out_ready=0, three operands offered -> two jobs complete; in_ready=0 with count 2; the third job is accepted only after one pop; results are delivered in order.
REQ-037 Timeout: TIMEOUT=64, engine never asserts busy -> err=1 at the 63rd WAIT_ACK cycle; state IDLE; out_valid=0; jobs=0; the next job completes normally with err still 1.
REQ-038 Simultaneous push/pop: FIFO holds 1 entry, out_ready=1 on the completion edge -> count stays 1 and the head advances to the new result.
REQ-039 Reset mid-job: reset asserted in WAIT_DONE -> all outputs at reset values immediately; the later eng_ready causes no push.
REQ-040 Wrap: 256 completed jobs -> jobs returns to 8'h00.
